// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial D = A - B - Bin, LSB first, one full-subtractor cell plus borrow flop.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             V,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [CW-1:0] cnt;
  logic br, a_i, b_i, d_i, br_next;
  assign a_i = a_sh[0];
  assign b_i = b_sh[0];
  assign d_i = a_i ^ b_i ^ br;
  assign br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_sh <= '0;
      b_sh <= '0;
      br <= 1'b0;
      cnt <= '0;
      D <= '0;
      Bout <= 1'b0;
      V <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      case (state)
        SHIFT: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          br <= br_next;
          D <= {d_i, D[WIDTH-1:1]};
          cnt <= cnt + CW'(1);
          // last bit: br is the borrow into the MSB, br_next the borrow out
          if (cnt == CW'(WIDTH-1)) begin
            V <= br ^ br_next;
            Bout <= br_next;
            busy <= 1'b0;
            done <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          done <= 1'b0;
          if (start) begin
            a_sh <= A;
            b_sh <= B;
            br <= Bin;
            cnt <= '0;
            D <= '0;
            busy <= 1'b1;
            state <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and swept checks of serial_subtractor via a done-driven scoreboard.
module tb_serial_subtractor;
  localparam int W = 8;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, Bin = 1'b0;
  logic [W-1:0] A = '0, B = '0, D;
  logic Bout, V, busy, done;
  int total = 0, bad = 0, cyc = 0, brun = 0;
  typedef struct {
    logic [W-1:0] a, b, d;
    logic bin, bo, v;
  } item_t;
  item_t q[$];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .Bin(Bin),
    .D(D), .Bout(Bout), .V(V), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic item_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    item_t it;
    logic [W:0] r;
    int sa, sb, s;
    r = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
    sa = $signed(a);
    sb = $signed(b);
    s = sa - sb - int'(bin);
    it.a = a; it.b = b; it.bin = bin;
    it.d = r[W-1:0];
    it.bo = r[W];
    it.v = (s < -(1 << (W-1))) || (s > (1 << (W-1)) - 1);
    return it;
  endfunction

  // monitor: pops one expected result per done pulse
  always @(negedge clk) begin
    if (rst) brun = 0;
    else begin
      if (busy && done) chk("busy_done_excl", 1, 0);
      if (busy) brun++;
      if (done) begin
        if (q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          item_t e;
          e = q.pop_front();
          $display("%h %h %b | %h %b %b", e.a, e.b, e.bin, D, Bout, V);
          chk("D", D, e.d);
          chk("Bout", Bout, e.bo);
          chk("V", V, e.v);
          chk("busy_cycles", brun, W);
        end
        brun = 0;
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin, input bit push);
    A = a; B = b; Bin = bin; start = 1'b1;
    if (push) q.push_back(model(a, b, bin));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int t);
    int n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!done) chk("done_timeout", 0, 1);
    t = cyc;
  endtask

  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    int t;
    issue(a, b, bin, 1);
    wait_done(t);
    @(negedge clk);
  endtask

  initial begin
    int t1, t2, t3;
    logic [W-1:0] cv [4];
    cv[0] = 8'h00; cv[1] = 8'h7F; cv[2] = 8'h80; cv[3] = 8'hFF;
    repeat (2) @(negedge clk);
    chk("rst_D", D, 0); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    chk("rst_Bout", Bout, 0); chk("rst_V", V, 0);
    rst = 1'b0;
    @(negedge clk);
    op(8'h05, 8'h03, 0);
    op(8'h00, 8'h01, 0);
    op(8'h80, 8'h01, 0);
    op(8'h7F, 8'hFF, 0);
    op(8'h10, 8'h0F, 1);
    op(8'h00, 8'h00, 1);
    // start held through SHIFT with operands changing: must use the originals
    A = 8'h40; B = 8'h01; Bin = 1'b0; start = 1'b1;
    q.push_back(model(8'h40, 8'h01, 0));
    @(negedge clk);
    A = 8'hAA; B = 8'h55; Bin = 1'b1;
    repeat (7) @(negedge clk);
    start = 1'b0;
    wait_done(t1);
    repeat (12) @(negedge clk);
    chk("no_restart_busy", busy, 0);
    // back-to-back: start issued in the DONE cycle
    issue(8'h33, 8'h11, 0, 1);
    wait_done(t1);
    issue(8'h01, 8'h02, 1, 1);
    wait_done(t2);
    issue(8'hC0, 8'h40, 0, 1);
    wait_done(t3);
    chk("b2b_gap1", t2 - t1, W + 1);
    chk("b2b_gap2", t3 - t2, W + 1);
    @(negedge clk);
    // asynchronous reset in the fourth SHIFT cycle aborts silently
    issue(8'h22, 8'h11, 0, 0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_D", D, 0); chk("abort_busy", busy, 0); chk("abort_done", done, 0);
    chk("abort_Bout", Bout, 0); chk("abort_V", V, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("abort_no_busy", busy, 0);
    op(8'h9C, 8'h37, 1);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        for (int k = 0; k < 2; k++)
          op(cv[i], cv[j], k[0]);
    for (int n = 0; n < 1000; n++)
      op(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial, sequential counterpart to the team's combinational full adder: computes D = A - B - Bin one bit per clock, LSB first.
- Uses a single full-subtractor cell plus a borrow flip-flop, shift registers and a control FSM.
- Sits alongside the adder blocks as a low-area arithmetic unit, driven by a start/busy/done handshake.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a subtraction; sampled on rising clk edges only while in IDLE or DONE.
- A  input  WIDTH  minuend; captured on an accepted start.
- B  input  WIDTH  subtrahend; captured on an accepted start.
- Bin  input  1  borrow-in; captured on an accepted start.
- D  output  WIDTH  difference; valid while done=1, held until the next accepted start.
- Bout  output  1  borrow out of the MSB; valid and held with D.
- V  output  1  signed (two's-complement) overflow; valid and held with D.
- busy  output  1  high while bits are being processed.
- done  output  1  single-cycle pulse when D, Bout and V become valid.

Behaviour:
- Reset (asynchronous, takes effect immediately, any state): state=IDLE; D=0, Bout=0, V=0, busy=0, done=0; bit counter=0; borrow register=0; operand shift registers=0.
- FSM states are IDLE, SHIFT and DONE.
  - IDLE: start=1 at a clock edge latches A, B and Bin into the shift registers and borrow register, clears the counter, clears D, and goes to SHIFT.
  - SHIFT: busy=1. Each cycle processes bit i = counter:
    - d_i = a_i ^ b_i ^ br
    - br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br)
  - d_i shifts into D from the MSB side, so after WIDTH cycles D[0] holds bit 0.
  - The counter increments each cycle. On the cycle processing bit WIDTH-1:
    - record V = (borrow into MSB) XOR (borrow out of MSB)
    - Bout = br_next
    - go to DONE.
  - DONE: done=1 and busy=0 for exactly one cycle. Next state is IDLE, or SHIFT if start=1 in this cycle. A start accepted here behaves exactly like a start accepted in IDLE (back-to-back operation).
- Latency: with start accepted at edge 0, busy is high for cycles 1..WIDTH and done is high in cycle WIDTH+1. Throughput is one result per WIDTH+1 cycles.
- start while in SHIFT is ignored. A, B and Bin changing during SHIFT have no effect.
- D, Bout and V are not updated during SHIFT except for D's internal shifting. D reads as partial data while busy=1 and is defined only when done=1. The final values hold through IDLE until the next accepted start clears D.
- busy and done are never high in the same cycle.
- Arithmetic wraps modulo 2^WIDTH.
  - Bout=1 exactly when the unsigned result A < B + Bin.
  - V=1 exactly when the signed result of A - B - Bin lies outside [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- Reset asserted mid-SHIFT aborts the operation. After release the block sits in IDLE with all outputs 0, and no done pulse is produced for the aborted operation.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- WIDTH=8, A=0x05, B=0x03, Bin=0, start pulse -> busy high for 8 cycles, done in cycle 9, D=0x02, Bout=0, V=0.
- A=0x00, B=0x01, Bin=0 -> D=0xFF, Bout=1, V=0. A=0x80, B=0x01, Bin=0 -> D=0x7F, Bout=0, V=1. A=0x7F, B=0xFF, Bin=0 -> D=0x80, Bout=1, V=1.
- Borrow-in: A=0x10, B=0x0F, Bin=1 -> D=0x00, Bout=0, V=0. A=0x00, B=0x00, Bin=1 -> D=0xFF, Bout=1, V=0.
- Handshake:
  - start held high through SHIFT with A changed mid-operation -> result uses the original operands and no restart occurs.
  - start asserted in the DONE cycle -> next operation begins with no IDLE gap, and done pulses every 9 cycles.
- Reset mid-operation: assert rst at cycle 4 of SHIFT -> outputs 0 immediately (asynchronous) and no done pulse. A new start after release -> correct result.
- Self-checking sweep: 1000 random (A, B, Bin) plus all corner values 0x00/0x7F/0x80/0xFF -> {Bout, D} == (A - B - Bin) mod 2^9, and V matches the signed reference. Display a table of A B Bin | D Bout V.
